// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - ID-stage immediate extraction with registered imm/format/valid/illegal outputs
module imm_decode_stage #(
  parameter int BRANCH_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [63:0] imm_out,
  output logic [2:0]  imm_fmt,
  output logic        out_valid,
  output logic        illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_D    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_CB   = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;

  logic [2:0]  dec_fmt;
  logic [63:0] dec_imm;
  logic        unused_bits;

  // Rt/Rd field carries no immediate information.
  assign unused_bits = ^instr_in[4:0];

  always_comb begin
    dec_fmt = FMT_NONE;
    dec_imm = 64'd0;
    if (instr_in[31:26] == 6'b000101) begin
      dec_fmt = FMT_B;
      dec_imm = {{38{instr_in[25]}}, instr_in[25:0]};
    end else if (instr_in[31:24] == 8'b10110100 || instr_in[31:24] == 8'b10110101 ||
                 instr_in[31:24] == 8'b01010100) begin
      dec_fmt = FMT_CB;
      dec_imm = {{45{instr_in[23]}}, instr_in[23:5]};
    end else if (instr_in[31:21] == 11'b11111000010 || instr_in[31:21] == 11'b11111000000) begin
      dec_fmt = FMT_D;
      dec_imm = {{55{instr_in[20]}}, instr_in[20:12]};
    end else if (instr_in[31:22] == 10'b1001000100 || instr_in[31:22] == 10'b1101000100) begin
      dec_fmt = FMT_I;
      dec_imm = {52'd0, instr_in[21:10]};
    end else if (instr_in[31:23] == 9'b110100101) begin
      dec_fmt = FMT_IW;
      dec_imm = {48'd0, instr_in[20:5]} << {instr_in[22:21], 4'b0000};
    end
    // Byte-offset branch targets: scale word offsets by 4.
    if (BRANCH_SHIFT != 0 && (dec_fmt == FMT_B || dec_fmt == FMT_CB)) begin
      dec_imm = dec_imm << 2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      imm_out   <= 64'd0;
      imm_fmt   <= FMT_NONE;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        imm_out   <= dec_imm;
        imm_fmt   <= dec_fmt;
        out_valid <= 1'b1;
        illegal   <= (dec_fmt == FMT_NONE);
      end else begin
        imm_out   <= 64'd0;
        imm_fmt   <= FMT_NONE;
        out_valid <= 1'b0;
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized and directed checks of imm_decode_stage against a bench model
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] instr_in;
  logic [63:0] imm_out [2];
  logic [2:0]  imm_fmt [2];
  logic        out_valid [2];
  logic        illegal [2];

  logic [63:0] m_imm [2];
  logic [2:0]  m_fmt [2];
  logic        m_valid [2];
  logic        m_ill [2];

  int checks = 0;
  int failures = 0;
  bit started = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.BRANCH_SHIFT(0)) u_bs0 (
    .clk(clk), .reset(reset), .instr_in(instr_in), .in_valid(in_valid),
    .stall(stall), .flush(flush), .imm_out(imm_out[0]), .imm_fmt(imm_fmt[0]),
    .out_valid(out_valid[0]), .illegal(illegal[0]));

  imm_decode_stage #(.BRANCH_SHIFT(1)) u_bs1 (
    .clk(clk), .reset(reset), .instr_in(instr_in), .in_valid(in_valid),
    .stall(stall), .flush(flush), .imm_out(imm_out[1]), .imm_fmt(imm_fmt[1]),
    .out_valid(out_valid[1]), .illegal(illegal[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Two's-complement value of an n-bit field, as plain arithmetic.
  function automatic longint sfield(input logic [31:0] raw, input int n);
    longint v;
    v = longint'(raw) & ((longint'(1) << n) - 1);
    if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    return v;
  endfunction

  function automatic void model_dec(input logic [31:0] w, input bit bs,
                                    output logic [2:0] f, output logic [63:0] v);
    longint s;
    f = 3'd0;
    v = 64'd0;
    if (w[31:26] == 6'b000101) begin
      f = 3'd3;
      s = sfield({6'd0, w[25:0]}, 26);
      v = bs ? s * 4 : s;
    end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5 || w[31:24] == 8'h54) begin
      f = 3'd4;
      s = sfield({13'd0, w[23:5]}, 19);
      v = bs ? s * 4 : s;
    end else if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
      f = 3'd2;
      v = sfield({23'd0, w[20:12]}, 9);
    end else if (w[31:22] == 10'h244 || w[31:22] == 10'h344) begin
      f = 3'd1;
      v = 64'(w[21:10]);
    end else if (w[31:23] == 9'h1A5) begin
      f = 3'd5;
      v = 64'(w[20:5]) * (64'd1 << (16 * w[22:21]));
    end
  endfunction

  always @(posedge clk) begin
    logic [2:0]  f;
    logic [63:0] v;
    for (int k = 0; k < 2; k++) begin
      if (reset || flush) begin
        m_imm[k] = 0; m_fmt[k] = 0; m_valid[k] = 0; m_ill[k] = 0;
      end else if (!stall) begin
        if (in_valid) begin
          model_dec(instr_in, k[0], f, v);
          m_imm[k] = v; m_fmt[k] = f; m_valid[k] = 1; m_ill[k] = (f == 3'd0);
        end else begin
          m_imm[k] = 0; m_fmt[k] = 0; m_valid[k] = 0; m_ill[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_imm[%0d]", k), imm_out[k], m_imm[k]);
        chk($sformatf("model_fmt[%0d]", k), 64'(imm_fmt[k]), 64'(m_fmt[k]));
        chk($sformatf("model_valid[%0d]", k), 64'(out_valid[k]), 64'(m_valid[k]));
        chk($sformatf("model_illegal[%0d]", k), 64'(illegal[k]), 64'(m_ill[k]));
        chk($sformatf("illegal_implies_valid[%0d]", k), 64'(illegal[k] & ~out_valid[k]), 64'd0);
      end
    end
  end

  // Called at a falling edge: apply inputs, return at the next falling edge.
  task automatic drive(input logic r, input logic [31:0] w, input logic v,
                       input logic s, input logic f);
    reset = r; instr_in = w; in_valid = v; stall = s; flush = f;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int k, input logic [63:0] imm,
                            input logic [2:0] fmt, input logic vld, input logic ill);
    chk({name, "_imm"}, imm_out[k], imm);
    chk({name, "_fmt"}, 64'(imm_fmt[k]), 64'(fmt));
    chk({name, "_valid"}, 64'(out_valid[k]), 64'(vld));
    chk({name, "_illegal"}, 64'(illegal[k]), 64'(ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:26] = 6'b000101;
      1: case ($urandom_range(0, 2))
           0: r[31:24] = 8'hB4;
           1: r[31:24] = 8'hB5;
           default: r[31:24] = 8'h54;
         endcase
      2: r[31:21] = $urandom_range(0, 1) ? 11'h7C2 : 11'h7C0;
      3: r[31:22] = $urandom_range(0, 1) ? 10'h244 : 10'h344;
      4: r[31:23] = 9'h1A5;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1; instr_in = 0; in_valid = 0; stall = 0; flush = 0;
    @(negedge clk);
    drive(1, 32'h913FFC41, 1, 1, 1);
    started = 1;
    expect_out("reset", 0, 64'd0, 3'd0, 0, 0);

    drive(0, 32'h913FFC41, 1, 0, 0);
    expect_out("addi", 0, 64'h0000000000000FFF, 3'd1, 1, 0);
    drive(0, 32'hF85F0000, 1, 0, 0);
    expect_out("ldur", 0, 64'hFFFFFFFFFFFFFFF0, 3'd2, 1, 0);
    drive(0, 32'hD2D7DDE0, 1, 0, 0);
    expect_out("movz", 0, 64'h0000BEEF00000000, 3'd5, 1, 0);
    drive(0, 32'h17FFFFFF, 1, 0, 0);
    expect_out("b_bs0", 0, 64'hFFFFFFFFFFFFFFFF, 3'd3, 1, 0);
    expect_out("b_bs1", 1, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1, 0);
    drive(0, 32'hB4FFFFE0, 1, 0, 0);
    expect_out("cbz_bs0", 0, 64'hFFFFFFFFFFFFFFFF, 3'd4, 1, 0);
    expect_out("cbz_bs1", 1, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1, 0);

    drive(0, 32'h913FFC41, 1, 0, 0);
    drive(0, 32'hF85F0000, 1, 1, 0);
    expect_out("stall1", 0, 64'hFFF, 3'd1, 1, 0);
    drive(0, 32'h00000000, 1, 1, 0);
    expect_out("stall2", 0, 64'hFFF, 3'd1, 1, 0);
    drive(0, 32'hD2D7DDE0, 0, 1, 0);
    expect_out("stall3", 0, 64'hFFF, 3'd1, 1, 0);
    drive(0, 32'hD2D7DDE0, 1, 1, 1);
    expect_out("stall_flush", 0, 64'd0, 3'd0, 0, 0);

    drive(0, 32'h00000000, 1, 0, 0);
    expect_out("illegal", 0, 64'd0, 3'd0, 1, 1);
    drive(0, 32'h00000000, 0, 0, 0);
    expect_out("idle", 0, 64'd0, 3'd0, 0, 0);

    drive(0, 32'hF85F0000, 1, 0, 0);
    drive(0, 32'h913FFC41, 1, 1, 0);
    expect_out("ldur_hold", 0, 64'hFFFFFFFFFFFFFFF0, 3'd2, 1, 0);
    drive(1, 32'h913FFC41, 1, 1, 0);
    expect_out("reset_mid_stall", 0, 64'd0, 3'd0, 0, 0);
    drive(0, 32'h913FFC41, 0, 0, 0);
    expect_out("post_reset_idle", 0, 64'd0, 3'd0, 0, 0);
    drive(0, 32'h913FFC41, 1, 1, 0);
    expect_out("post_reset_stall", 0, 64'd0, 3'd0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 3, rand_instr(), $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10);
    end

    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter: BRANCH_SHIFT, default 0, meaning: 1 = B/CB immediates left-shifted by 2 (byte offset); 0 = word offset unshifted.
REQ-002 Port: clk  input  1  rising-edge clock; only clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-004 Port: instr_in  input  32  instruction word from IF/ID register.
REQ-005 Port: in_valid  input  1  instr_in holds a real instruction this cycle.
REQ-006 Port: stall  input  1  hazard stall; hold all outputs.
REQ-007 Port: flush  input  1  squash; insert bubble.
REQ-008 Port: imm_out  output  64  registered, extended immediate for the EX-stage operand mux.
REQ-009 Port: imm_fmt  output  3  registered format code: 0 NONE, 1 I, 2 D, 3 B, 4 CB, 5 IW.
REQ-010 Port: out_valid  output  1  registered; imm_out/imm_fmt belong to a valid instruction.
REQ-011 Port: illegal  output  1  registered; valid instruction matched no known opcode.

Function
REQ-012 Decode, combinational, on instr_in; opcode patterns are mutually exclusive:
- [31:26]=000101 (B) -> fmt 3, imm26=[25:0], sign-extend
- [31:24]=10110100/10110101/01010100 (CBZ/CBNZ/B.cond) -> fmt 4, imm19=[23:5], sign-extend
- [31:21]=11111000010/11111000000 (LDUR/STUR) -> fmt 2, imm9=[20:12], sign-extend
- [31:22]=1001000100/1101000100 (ADDI/SUBI) -> fmt 1, imm12=[21:10], zero-extend
- [31:23]=110100101 (MOVZ) -> fmt 5, imm16=[20:5] zero-extended, shifted left by 16*hw, hw=[22:21]
- anything else -> fmt 0, imm 0, illegal candidate.
REQ-013 BRANCH_SHIFT=1: fmt 3/4 result = sign-extended value << 2, truncated to 64 bits; other formats unaffected.
REQ-014 Latency: exactly 1 cycle from instr_in/in_valid to registered outputs.
REQ-015 Update rule, priority order, each rising edge:
- reset -> all outputs 0
- else flush -> out_valid=0, illegal=0, imm_out=0, imm_fmt=0 (flush overrides stall)
- else stall -> all outputs hold previous values
- else in_valid=1 -> load decoded imm/fmt; out_valid=1; illegal=1 iff fmt 0
- else (in_valid=0) -> out_valid=0, illegal=0, imm_out=0, imm_fmt=0.
REQ-016 illegal is never 1 when out_valid is 0.
REQ-017 Stall for N consecutive cycles holds outputs bit-identical for N cycles; the instruction presented on the first non-stalled cycle is captured.
REQ-018 Flush and stall asserted together -> bubble, not hold.
REQ-019 No X propagation: any X-free instr_in yields X-free outputs.

Reset
REQ-020 Reset is synchronous, active-high; with reset=1 at a rising edge, imm_out=0, imm_fmt=0, out_valid=0, illegal=0 after that edge, regardless of stall/flush/in_valid.
REQ-021 Reset asserted mid-stall discards the held instruction; first post-reset capture requires in_valid=1 with stall=0.

Verification
REQ-022 ADDI: instr_in=0x913FFC41, in_valid=1 -> next cycle imm_out=0x0000000000000FFF, imm_fmt=1, out_valid=1, illegal=0.
REQ-023 LDUR: instr_in=0xF85F0000 -> imm_out=0xFFFFFFFFFFFFFFF0, imm_fmt=2; MOVZ instr_in=0xD2D7DDE0 -> imm_out=0x0000BEEF00000000, imm_fmt=5.
REQ-024 B: instr_in=0x17FFFFFF -> imm_out=0xFFFFFFFFFFFFFFFF (BRANCH_SHIFT=0) / 0xFFFFFFFFFFFFFFFC (BRANCH_SHIFT=1), imm_fmt=3.
REQ-025 Stall/flush: capture ADDI 0x913FFC41, stall=1 for 3 cycles with instr_in changing -> imm_out stays 0xFFF; then stall=1 and flush=1 together -> out_valid=0, imm_out=0.
REQ-026 Illegal: instr_in=0x00000000, in_valid=1 -> out_valid=1, illegal=1, imm_fmt=0, imm_out=0; same word with in_valid=0 -> out_valid=0, illegal=0.
REQ-027 Reset mid-stall: hold LDUR result, assert reset=1 one cycle -> all outputs 0 next cycle; after deassert with in_valid=0, outputs stay 0.
